// File: rtl/mem_access_unit.sv
// Load/store unit between a byte-addressed request port and a word-wide data memory.
// Sub-word stores are done as read-modify-write through the MERGE state.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_wen,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       cap_q, cap_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic        req_bad;
    logic [31:0] byte_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_bad = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_bad ? RESP : ACCESS;
            ACCESS:  state_d = (we_q && size_q != 2'b10) ? MERGE : RESP;
            MERGE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads, little-endian within the word.
    always_comb begin
        byte_sh  = dm_rdata >> {addr_q[1:0], 3'b000};
        lane_b   = byte_sh[7:0];
        lane_h   = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_ext = dm_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = dm_rdata;
        endcase
    end

    always_comb begin
        merged = cap_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d       = req_we;
                size_d     = req_size;
                uns_d      = req_unsigned;
                addr_d     = req_addr;
                wdata_d    = req_wdata;
                rsp_data_d = '0;
                rsp_err_d  = req_bad;
            end
            ACCESS: begin
                if (!we_q)                    rsp_data_d = load_ext;
                else if (size_q != 2'b10)     cap_d      = dm_rdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        dm_addr   = addr_q[ADDR_W+1:2];
        dm_wen    = (state_q == MERGE) ||
                    (state_q == ACCESS && we_q && size_q == 2'b10);
        dm_wdata  = (state_q == MERGE) ? merged : wdata_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes model-predicted responses,
// a negedge monitor pops and compares them against what the unit presents.
module tb_mem_access_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic [AW-1:0] dm_addr;
    logic          dm_wen;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .dm_addr(dm_addr),
        .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT, and the model's own view of what it should contain.
    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_wen) mem[dm_addr] <= dm_wdata;

    typedef struct {
        logic [31:0]   data;
        logic          err;
        int            lat;
        int            wen;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
    } exp_t;
    exp_t sb[$];

    int pass_cnt = 0, total = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int hs_cnt = 0;
    int wen_cnt = 0;
    logic [AW-1:0] wen_addr;
    logic [31:0]   wen_data;
    logic stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: plain byte-lane arithmetic over a word array.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] wd, output exp_t e);
        logic [31:0] w, v, mask;
        int sh;
        w  = ref_mem[a >> 2];
        sh = 8 * int'(a[1:0]);
        e.data = 0; e.err = 0; e.wen = 0; e.waddr = a >> 2; e.wdata = 0; e.lat = 2;
        if (sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0)) begin
            e.err = 1; e.lat = 1;
        end else if (!we) begin
            if (sz == 2) e.data = w;
            else begin
                mask = (sz == 0) ? 32'hFF : 32'hFFFF;
                v = (w >> sh) & mask;
                if (!uns && v > (mask >> 1)) v = v | ~mask;
                e.data = v;
            end
        end else begin
            e.wen = 1;
            if (sz == 2) e.wdata = wd;
            else begin
                mask = (sz == 0) ? 32'hFF : 32'hFFFF;
                e.wdata = (w & ~(mask << sh)) | ((wd & mask) << sh);
                e.lat = 3;
            end
            ref_mem[a >> 2] = e.wdata;
        end
    endtask

    // Issue one request (caller is at posedge+1 with the unit idle) and wait for its handshake.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [AW+1:0] a, input logic [31:0] wd);
        exp_t e;
        int target, n;
        model(we, sz, uns, a, wd, e);
        sb.push_back(e);
        target = hs_cnt + 1;
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0;
        accept_cyc = cyc;
        n = 0;
        while (hs_cnt < target && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (hs_cnt < target) begin
            chk("rsp_timeout", 32'(hs_cnt), 32'(target));
            sb.delete();
            rst_n = 0; #2 rst_n = 1;
            for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        end
    endtask

    // Monitor: latency, hold-while-stalled, handshake compare, post-handshake idle.
    initial begin
        logic prev_v, prev_r, prev_e, post_hs;
        logic [31:0] prev_d;
        int first_lat;
        exp_t e;
        prev_v = 0; prev_r = 0; prev_e = 0; prev_d = 0; post_hs = 0; first_lat = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0; post_hs = 0;
            end else begin
                if (dm_wen) begin
                    wen_cnt++; wen_addr = dm_addr; wen_data = dm_wdata;
                end
                if (post_hs) begin
                    chk("idle_after_rsp", {30'h0, req_ready, rsp_valid}, 32'h2);
                    post_hs = 0;
                end
                if (prev_v && !prev_r) begin
                    chk("hold_valid", 32'(rsp_valid), 32'h1);
                    chk("hold_data", rsp_data, prev_d);
                    chk("hold_err", 32'(rsp_err), 32'(prev_e));
                end
                if (rsp_valid) begin
                    if (!prev_v) first_lat = cyc - accept_cyc + 1;
                    if (!rsp_ready) chk("req_ready_busy", 32'(req_ready), 32'h0);
                    if (rsp_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_rsp", 32'h1, 32'h0);
                        end else begin
                            e = sb.pop_front();
                            chk("rsp_data", rsp_data, e.data);
                            chk("rsp_err", 32'(rsp_err), 32'(e.err));
                            chk("latency", 32'(first_lat), 32'(e.lat));
                            chk("wen_pulses", 32'(wen_cnt), 32'(e.wen));
                            if (e.wen == 1) begin
                                chk("wen_addr", 32'(wen_addr), 32'(e.waddr));
                                chk("wen_data", wen_data, e.wdata);
                            end
                        end
                        wen_cnt = 0;
                        post_hs = 1;
                        hs_cnt++;
                    end
                end
                prev_v = rsp_valid; prev_r = rsp_ready; prev_d = rsp_data; prev_e = rsp_err;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = (i < 16) ? $urandom : 32'h0;
            ref_mem[i] = mem[i];
        end
        mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;

        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_outs", {rsp_data | dm_wdata, 30'h0, dm_wen, rsp_err}, 64'h0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Directed cases on word 3.
        do_req(0, 2'b00, 0, 12'h00D, 32'h0);
        do_req(0, 2'b00, 1, 12'h00D, 32'h0);
        do_req(0, 2'b01, 0, 12'h00E, 32'h0);
        do_req(1, 2'b00, 0, 12'h00D, 32'h12345655);
        chk("sb_mem_word3", mem[3], 32'h889955BB);
        do_req(1, 2'b01, 0, 12'h00D, 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 12'h00E, 32'h0);
        do_req(0, 2'b11, 0, 12'h00C, 32'h0);

        // Stalled word load: response must hold for three cycles.
        stall = 1;
        fork
            do_req(0, 2'b10, 0, 12'h00C, 32'h0);
            begin repeat (5) @(posedge clk); stall = 0; end
        join

        // Word store then load of the same word.
        do_req(1, 2'b10, 0, 12'h014, 32'hCAFEF00D);
        do_req(0, 2'b10, 0, 12'h014, 32'h0);

        // Reset during MERGE of a halfword store.
        wen_cnt = 0;
        req_valid = 1; req_we = 1; req_size = 2'b01; req_unsigned = 0;
        req_addr = 12'h01A; req_wdata = 32'h0000ABCD;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk); #1;
        chk("merge_wen", 32'(dm_wen), 32'h1);
        rst_n = 0;
        #1;
        chk("mid_rst_wen", 32'(dm_wen), 32'h0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_addr", 32'(dm_addr), 32'h0);
        chk("mid_rst_wdata", dm_wdata, 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_wen", 32'(wen_cnt), 32'h0);
        chk("post_rst_mem", mem[6], ref_mem[6]);
        chk("post_rst_valid", 32'(rsp_valid), 32'h0);

        // Randomized traffic over a 16-word window.
        for (int k = 0; k < 200; k++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom);
        end

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
